// File: rtl/inertial_intf.sv
// inertial_intf
// Producer end of the inertial data path. After reset it waits for the
// sensor to settle, then writes four configuration registers through an
// existing 16-bit SPI master. From then on, every data-ready interrupt from
// the sensor starts a read of the pitch-rate and Z-acceleration byte pairs.
// Once all four bytes have arrived, the two 16-bit words are presented
// together with a one-cycle vld strobe.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   INT      in   sensor data-ready interrupt (asynchronous to clk)
//   done     in   SPI master transaction complete, single-cycle pulse
//   rd_data  in   SPI master read data; only [7:0] carries a register byte
//   wrt      out  single-cycle pulse that starts an SPI transaction
//   cmd      out  SPI command word, held until the next wrt
//   vld      out  single-cycle pulse: ptch_rt / AZ just updated
//   ptch_rt  out  signed raw pitch rate {PH,PL}
//   AZ       out  signed raw Z acceleration {AH,AL}

module inertial_intf #(
  parameter int          INIT_WAIT_BITS = 16,
  parameter logic [15:0] INIT_CMD0      = 16'h0D02,
  parameter logic [15:0] INIT_CMD1      = 16'h1053,
  parameter logic [15:0] INIT_CMD2      = 16'h1150,
  parameter logic [15:0] INIT_CMD3      = 16'h1460
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  // SPI read commands for the four data registers (pitch low/high,
  // Z-accel low/high).
  localparam logic [15:0] RD_PL_CMD = 16'hA200;
  localparam logic [15:0] RD_PH_CMD = 16'hA300;
  localparam logic [15:0] RD_AL_CMD = 16'hAC00;
  localparam logic [15:0] RD_AH_CMD = 16'hAD00;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT0,
    INIT1,
    INIT2,
    INIT3,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  state_t                    state_q;
  logic [INIT_WAIT_BITS-1:0] timer_q;

  logic intMeta_q;
  logic intSync_q;
  logic intPrev_q;
  logic intTrigger;

  logic [7:0] plByte_q;
  logic [7:0] phByte_q;
  logic [7:0] alByte_q;
  logic [7:0] ahByte_q;

  logic        wrt_q;
  logic [15:0] cmd_q;
  logic        vld_q;
  logic [15:0] ptchRt_q;
  logic [15:0] az_q;

  // The upper byte of the SPI read word is not a register value.
  logic unusedRdHigh;
  assign unusedRdHigh = ^rd_data[15:8];

  // The trigger fires once per rising edge of the synchronised interrupt,
  // so a sensor that keeps INT high does not start more reads.
  assign intTrigger = intSync_q & ~intPrev_q;

  // INT is brought into the clk domain through two flops. The third flop
  // holds the previous synchronised value for the edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intMeta_q <= 1'b0;
      intSync_q <= 1'b0;
      intPrev_q <= 1'b0;
    end else begin
      intMeta_q <= INT;
      intSync_q <= intMeta_q;
      intPrev_q <= intSync_q;
    end
  end

  // Main sequencer. All outputs are registered here.
  // wrt and vld default low, so each is a single-cycle pulse.
  // cmd holds its value until the next wrt.
  // Bytes are staged in holding registers. ptch_rt and AZ change only when
  // the final byte arrives, so a half-finished sample never appears on the
  // outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT_WAIT;
      timer_q  <= '0;
      wrt_q    <= 1'b0;
      cmd_q    <= 16'h0000;
      vld_q    <= 1'b0;
      ptchRt_q <= 16'h0000;
      az_q     <= 16'h0000;
      plByte_q <= 8'h00;
      phByte_q <= 8'h00;
      alByte_q <= 8'h00;
      ahByte_q <= 8'h00;
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      case (state_q)
        // The timer stops counting once it reaches all-ones, because the
        // sequencer leaves this state at that point.
        INIT_WAIT: begin
          if (timer_q == '1) begin
            wrt_q   <= 1'b1;
            cmd_q   <= INIT_CMD0;
            state_q <= INIT0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        INIT0: begin
          if (done) begin
            wrt_q   <= 1'b1;
            cmd_q   <= INIT_CMD1;
            state_q <= INIT1;
          end
        end
        INIT1: begin
          if (done) begin
            wrt_q   <= 1'b1;
            cmd_q   <= INIT_CMD2;
            state_q <= INIT2;
          end
        end
        INIT2: begin
          if (done) begin
            wrt_q   <= 1'b1;
            cmd_q   <= INIT_CMD3;
            state_q <= INIT3;
          end
        end
        INIT3: begin
          if (done) begin
            state_q <= IDLE;
          end
        end
        // Only this state reacts to a trigger. A trigger that arrives while
        // a transaction is in flight is deliberately dropped, not queued.
        IDLE: begin
          if (intTrigger) begin
            wrt_q   <= 1'b1;
            cmd_q   <= RD_PL_CMD;
            state_q <= RD_PL;
          end
        end
        RD_PL: begin
          if (done) begin
            plByte_q <= rd_data[7:0];
            wrt_q    <= 1'b1;
            cmd_q    <= RD_PH_CMD;
            state_q  <= RD_PH;
          end
        end
        RD_PH: begin
          if (done) begin
            phByte_q <= rd_data[7:0];
            wrt_q    <= 1'b1;
            cmd_q    <= RD_AL_CMD;
            state_q  <= RD_AL;
          end
        end
        RD_AL: begin
          if (done) begin
            alByte_q <= rd_data[7:0];
            wrt_q    <= 1'b1;
            cmd_q    <= RD_AH_CMD;
            state_q  <= RD_AH;
          end
        end
        // The last byte goes straight onto the output word as well as into
        // its holding register. This makes vld appear exactly one clock
        // after the final done.
        RD_AH: begin
          if (done) begin
            ahByte_q <= rd_data[7:0];
            ptchRt_q <= {phByte_q, plByte_q};
            az_q     <= {rd_data[7:0], alByte_q};
            vld_q    <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= INIT_WAIT;
        end
      endcase
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptchRt_q;
  assign AZ      = az_q;

endmodule

// File: tb/tb_inertial_intf.sv
// tb_inertial_intf
// Scoreboard bench for inertial_intf. Stimulus pushes the expected SPI
// command words and output words into queues. A monitor pops and compares
// them whenever the DUT pulses wrt or vld. A small SPI slave model answers
// each wrt with a delayed done. For read commands it returns hand-chosen
// data bytes.

module tb_inertial_intf;

  localparam int SPI_DELAY = 6;

  logic        clk;
  logic        rst;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;

  int checks;
  int errors;
  int cycleCount;
  int lastAhDoneCycle;

  logic [15:0] expCmd[$];
  logic [15:0] expPr[$];
  logic [15:0] expAz[$];
  logic [7:0]  spiBytes[$];

  int          ackBudget;
  logic        spuriousReq;
  logic        spiPending;
  int          spiCountdown;
  logic [15:0] spiCmd;

  inertial_intf #(
    .INIT_WAIT_BITS(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .INT    (INT),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .cmd    (cmd),
    .vld    (vld),
    .ptch_rt(ptch_rt),
    .AZ     (AZ)
  );

  // Free-running clock and a cycle counter used for the latency check.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Queue the four configuration writes expected after a reset.
  task automatic pushInit();
    expCmd.push_back(16'h0D02);
    expCmd.push_back(16'h1053);
    expCmd.push_back(16'h1150);
    expCmd.push_back(16'h1460);
  endtask

  // One full sample: load the SPI slave with bytes, queue the expected
  // command sequence and the hand-computed result words, then raise INT.
  task automatic applyStimulus(input logic [7:0] pl, input logic [7:0] ph,
                               input logic [7:0] al, input logic [7:0] ah,
                               input logic [15:0] pr, input logic [15:0] az,
                               input bit holdHigh);
    spiBytes.push_back(pl);
    spiBytes.push_back(ph);
    spiBytes.push_back(al);
    spiBytes.push_back(ah);
    expCmd.push_back(16'hA200);
    expCmd.push_back(16'hA300);
    expCmd.push_back(16'hAC00);
    expCmd.push_back(16'hAD00);
    expPr.push_back(pr);
    expAz.push_back(az);
    INT = 1'b1;
    if (!holdHigh) begin
      repeat (4) @(negedge clk);
      INT = 1'b0;
    end
  endtask

  // Bounded wait until every expected command and output has been seen.
  task automatic waitDrained(input string name, input int maxCycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (expCmd.size() == 0 && expPr.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(name, {31'd0, ok}, 32'd1);
  endtask

  // Counts clock edges from reset release to the first wrt.
  task automatic waitFirstWrt(input string name, input int expected);
    int n;
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (wrt) begin
        n = i;
        break;
      end
    end
    checkOutput(name, n, expected);
  endtask

  // SPI slave model. Each wrt is acknowledged with done SPI_DELAY+1 cycles
  // later, as long as ackBudget allows. The upper rd_data byte carries junk.
  initial begin
    done = 1'b0;
    rd_data = 16'h0000;
    spiPending = 1'b0;
    spiCountdown = 0;
    spiCmd = 16'h0000;
    lastAhDoneCycle = -100;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (rst) begin
        spiPending = 1'b0;
      end else if (wrt) begin
        spiPending = (ackBudget > 0);
        if (ackBudget > 0) ackBudget--;
        spiCountdown = SPI_DELAY;
        spiCmd = cmd;
      end else if (spiPending) begin
        if (spiCountdown == 0) begin
          logic [7:0] b;
          b = 8'hC3;
          if (spiCmd[15] && spiBytes.size() > 0) b = spiBytes.pop_front();
          rd_data = {8'hA5, b};
          done = 1'b1;
          spiPending = 1'b0;
          if (spiCmd == 16'hAD00) lastAhDoneCycle = cycleCount;
        end else begin
          spiCountdown--;
        end
      end else if (spuriousReq) begin
        rd_data = 16'h5A3C;
        done = 1'b1;
        spuriousReq = 1'b0;
      end
    end
  end

  // Monitor: compares every wrt/cmd and vld/output word against the queues.
  // It also checks the pulse widths, the vld latency, and that the outputs
  // stay stable between vld pulses.
  initial begin
    logic        prevWrt;
    logic        prevVld;
    logic [15:0] holdPr;
    logic [15:0] holdAz;
    logic [15:0] e;
    prevWrt = 1'b0;
    prevVld = 1'b0;
    holdPr = 16'h0000;
    holdAz = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevWrt = 1'b0;
        prevVld = 1'b0;
        holdPr = 16'h0000;
        holdAz = 16'h0000;
      end else begin
        if (wrt) begin
          checkOutput("wrtPulseWidth", {31'd0, prevWrt}, 32'd0);
          if (expCmd.size() == 0) begin
            checkOutput("unexpectedWrt", {16'd0, cmd}, 32'hFFFFFFFF);
          end else begin
            e = expCmd.pop_front();
            checkOutput("cmdSeq", {16'd0, cmd}, {16'd0, e});
          end
        end
        if (vld) begin
          checkOutput("vldPulseWidth", {31'd0, prevVld}, 32'd0);
          checkOutput("vldLatency", cycleCount - lastAhDoneCycle, 32'd1);
          if (expPr.size() == 0) begin
            checkOutput("unexpectedVld", {16'd0, ptch_rt}, 32'hFFFFFFFF);
          end else begin
            e = expPr.pop_front();
            checkOutput("ptchRt", {16'd0, ptch_rt}, {16'd0, e});
            e = expAz.pop_front();
            checkOutput("az", {16'd0, AZ}, {16'd0, e});
          end
          holdPr = ptch_rt;
          holdAz = AZ;
        end else begin
          checkOutput("outputsHeld", {ptch_rt, AZ}, {holdPr, holdAz});
        end
        prevWrt = wrt;
        prevVld = vld;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    INT = 1'b0;
    spuriousReq = 1'b0;
    ackBudget = 1000;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("resetWrt", {31'd0, wrt}, 32'd0);
    checkOutput("resetCmd", {16'd0, cmd}, 32'd0);
    checkOutput("resetVld", {31'd0, vld}, 32'd0);
    checkOutput("resetPtch", {16'd0, ptch_rt}, 32'd0);
    checkOutput("resetAz", {16'd0, AZ}, 32'd0);

    // Init sequence: first wrt 16 clocks after release, then three more
    // configuration writes.
    pushInit();
    @(negedge clk);
    rst = 1'b0;
    waitFirstWrt("firstWrtDelay", 16);
    waitDrained("initDrained", 400);
    repeat (12) @(negedge clk);

    // Basic read: 34,12,F0,FF gives 1234 / FFF0.
    applyStimulus(8'h34, 8'h12, 8'hF0, 8'hFF, 16'h1234, 16'hFFF0, 1'b0);
    waitDrained("read1Drained", 400);
    checkOutput("ptchAfterRead1", {16'd0, ptch_rt}, 32'h1234);
    checkOutput("azAfterRead1", {16'd0, AZ}, 32'hFFF0);

    // INT held high: exactly one sequence. Then re-raise for a second one,
    // where FF,FF gives -1.
    applyStimulus(8'h78, 8'h56, 8'h00, 8'h80, 16'h5678, 16'h8000, 1'b1);
    waitDrained("holdHighDrained", 400);
    repeat (40) @(negedge clk);
    INT = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(8'h01, 8'h00, 8'hFF, 8'hFF, 16'h0001, 16'hFFFF, 1'b0);
    waitDrained("reRaiseDrained", 400);
    repeat (5) @(negedge clk);

    // INT pulse during RD_PH is dropped.
    applyStimulus(8'h34, 8'h12, 8'hF0, 8'hFF, 16'h1234, 16'hFFF0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (expCmd.size() <= 2) break;
      @(negedge clk);
    end
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    waitDrained("pulseInRdPhDrained", 400);
    repeat (30) @(negedge clk);
    checkOutput("ptchAfterDroppedPulse", {16'd0, ptch_rt}, 32'h1234);

    // Spurious done in IDLE: no wrt (any wrt is flagged by the monitor).
    spuriousReq = 1'b1;
    repeat (20) @(negedge clk);

    // Reset during RD_AL: outputs clear asynchronously, and init reruns.
    ackBudget = 2;
    spiBytes.push_back(8'h11);
    spiBytes.push_back(8'h22);
    expCmd.push_back(16'hA200);
    expCmd.push_back(16'hA300);
    expCmd.push_back(16'hAC00);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (expCmd.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checkOutput("ptchBeforeReset", {16'd0, ptch_rt}, 32'h1234);
    checkOutput("cmdBeforeReset", {16'd0, cmd}, 32'hAC00);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetPtch", {16'd0, ptch_rt}, 32'd0);
    checkOutput("asyncResetAz", {16'd0, AZ}, 32'd0);
    checkOutput("asyncResetCmd", {16'd0, cmd}, 32'd0);
    checkOutput("asyncResetWrt", {31'd0, wrt}, 32'd0);
    checkOutput("asyncResetVld", {31'd0, vld}, 32'd0);
    repeat (3) @(negedge clk);
    ackBudget = 1000;
    spiBytes.delete();
    pushInit();
    rst = 1'b0;
    waitFirstWrt("firstWrtAfterReset", 16);
    waitDrained("reinitDrained", 400);
    repeat (12) @(negedge clk);

    // Back-to-back samples, including the sign boundaries.
    applyStimulus(8'h00, 8'h80, 8'h01, 8'h00, 16'h8000, 16'h0001, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (expPr.size() == 0) break;
      @(negedge clk);
    end
    applyStimulus(8'hFF, 8'h7F, 8'h00, 8'h00, 16'h7FFF, 16'h0000, 1'b0);
    waitDrained("backToBackDrained", 400);
    repeat (10) @(negedge clk);

    checkOutput("cmdQueueLeft", expCmd.size(), 32'd0);
    checkOutput("outQueueLeft", expPr.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inertial_intf.md
Name: inertial_intf

Overview:
- Producer end of the inertial data interface: drives `vld`, `ptch_rt` and `AZ` into the pitch integrator.
- Configures the 6-axis inertial sensor over an existing 16-bit SPI master (`wrt`/`cmd`/`done`/`rd_data` handshake).
- Waits for the sensor's data-ready interrupt, reads the pitch-rate and Z-acceleration byte pairs, then presents them as two 16-bit signed words with a one-cycle `vld` strobe.

Parameters:
- INIT_WAIT_BITS, 16, width of the post-reset settle timer; the wait is 2^INIT_WAIT_BITS clocks (benches use 4).
- INIT_CMD0, 16'h0D02, first config write (interrupt enable on data ready).
- INIT_CMD1, 16'h1053, second config write (accel ODR/range).
- INIT_CMD2, 16'h1150, third config write (gyro ODR/range).
- INIT_CMD3, 16'h1460, fourth config write (rounding enable).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- INT  in  1  sensor data-ready interrupt, asynchronous to clk
- done  in  1  SPI master transaction complete, single-cycle pulse
- rd_data  in  16  SPI master read data; only [7:0] is used
- wrt  out  1  single-cycle pulse to start an SPI transaction
- cmd  out  16  SPI command word, valid in the cycle `wrt` is high and held until `done`
- vld  out  1  single-cycle pulse: new `ptch_rt`/`AZ` valid
- ptch_rt  out  16  signed raw pitch rate {PH,PL}
- AZ  out  16  signed raw Z acceleration {AH,AL}

Behaviour:
- Reset and clocking
  - One clock; reset is asynchronous and active-high.
  - While `rst`=1: state=INIT_WAIT, timer=0, `wrt`=0, `cmd`=0, `vld`=0, `ptch_rt`=0, `AZ`=0, all byte holding registers=0, `INT` synchronizer=0.
  - Reset asserted mid-transaction aborts immediately; no completion of the in-flight read; the init sequence reruns after release.
- INT synchronizer
  - `INT` passes through two flops.
  - A trigger is the rising edge of the second flop (a third flop holds the previous value).
  - A trigger occurs at most once per low-to-high transition, so a held-high `INT` does not retrigger.
- State machine
  - States: INIT_WAIT, INIT0, INIT1, INIT2, INIT3, IDLE, RD_PL, RD_PH, RD_AL, RD_AH.
  - INIT_WAIT: timer increments each clock. When it reaches all-ones, assert `wrt` with `cmd`=INIT_CMD0 and go to INIT0.
  - INITn (n=0..2): wait for `done`. On `done`, pulse `wrt` with INIT_CMD(n+1) in the same cycle and go to INIT(n+1).
  - INIT3: on `done` go to IDLE, no `wrt`.
  - IDLE: on trigger, pulse `wrt` with `cmd`=16'hA200 and go to RD_PL.
  - RD_PL: on `done`, capture PL=`rd_data`[7:0], pulse `wrt` with 16'hA300, go to RD_PH.
  - RD_PH: on `done`, capture PH, pulse `wrt` with 16'hAC00, go to RD_AL.
  - RD_AL: on `done`, capture AL, pulse `wrt` with 16'hAD00, go to RD_AH.
  - RD_AH: on `done`, capture AH, go to IDLE.
- Outputs
  - `wrt` is registered and high for exactly one cycle per transaction. A new `wrt` never occurs before the prior `done`.
  - `cmd` is registered and holds its value until the next `wrt`.
  - `ptch_rt`={PH,PL} and `AZ`={AH,AL} update in the cycle after the RD_AH `done`.
  - `vld` is high in that same cycle, for one clock only. Latency from the final `done` to `vld` is exactly 1 clock.
  - `ptch_rt`/`AZ` hold their values between `vld` pulses. Partial updates are never visible on the outputs; the bytes are staged internally.
- Boundary conditions
  - `done` in INIT_WAIT or IDLE is ignored.
  - A trigger during INIT*/RD_* is dropped, not queued; the next sample comes from the next `INT` edge.
  - A trigger in the same cycle as the RD_AH `done` is also dropped.
  - The timer saturates: it stops counting once INIT0 is entered.
  - Sign: bytes are concatenated unmodified. 8'hFF,8'hFF gives -1; there is no offset or scaling in this block.

Test Plan:
- Reset release, INIT_WAIT_BITS=4 → first `wrt` 16 clocks after release with `cmd`=16'h0D02. Ack each with `done` → `cmd` sequence 16'h1053, 16'h1150, 16'h1460, then state IDLE, `vld` never asserted.
- After init, raise `INT`. SPI model returns 8'h34, 8'h12, 8'hF0, 8'hFF → commands A200/A300/AC00/AD00 in order; `ptch_rt`=16'h1234, `AZ`=16'hFFF0 (-16); `vld` one cycle, 1 clock after the 4th `done`.
- Hold `INT` high through and beyond a full read → exactly one read sequence and one `vld`. Drop then re-raise `INT` → a second sequence.
- Pulse `INT` while in RD_PH → no extra sequence, outputs change only once. Spurious `done` in IDLE → no state change, no `wrt`.
- Assert `rst` during RD_AL with prior `ptch_rt`=16'h1234 → all outputs 0 asynchronously (before the next clk edge). After release, the full init sequence repeats before any read.
- Back-to-back samples 8'h00,8'h80,8'h01,8'h00 then 8'hFF,8'h7F,8'h00,8'h00 → `ptch_rt`=16'h8000 then 16'h7FFF, `AZ`=16'h0001 then 0. Outputs are stable between the two `vld` pulses.
